data_memory_responder: RTL and testbench

//  Word-addressed data RAM that answers the processor's memory-stage requests.
//  It receives MEM_Address/MEM_In/MEM_Read_H_Write_L and a request strobe, and returns MEM_Out with MFC.

---
 rtl/data_memory_responder.sv | 158 +++++++++++++++
 tb/tb_data_memory_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_responder
//  Description : Word-addressed single-port data RAM serving the processor's
//                memory stage over a 4-phase request / MFC handshake, with
//                programmable wait states and address-error flagging.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clock              in   1   rising-edge clock
//    Reset_L            in   1   asynchronous active-low reset
//    MEM_Request        in   1   request, held high until MFC is seen
//    MEM_Read_H_Write_L in   1   1 = read, 0 = write (sampled with request)
//    MEM_Address        in   32  byte address
//    MEM_In             in   32  write data (sampled with request)
//    MEM_Out            out  32  registered read data, valid while MFC=1
//    MFC                out  1   memory function complete
//    Busy               out  1   high from capture until return to idle
//    Address_Error      out  1   misaligned or out-of-range access
// ============================================================================
module data_memory_responder #(
    parameter int    DEPTH_LOG2  = 8,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        Clock,
    input  logic        Reset_L,
    input  logic        MEM_Request,
    input  logic        MEM_Read_H_Write_L,
    input  logic [31:0] MEM_Address,
    input  logic [31:0] MEM_In,
    output logic [31:0] MEM_Out,
    output logic        MFC,
    output logic        Busy,
    output logic        Address_Error
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [3:0]            wait_count;
    logic [31:0]           addr_q;
    logic [31:0]           data_q;
    logic                  read_q;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]           rd_word;
    logic                  addr_bad;
    logic                  capture;
    logic                  access;

    // Everything downstream of capture works from the latched copies, so the
    // initiator may change its buses freely once the request is taken.
    assign word_idx = addr_q[DEPTH_LOG2+1:2];
    assign rd_word  = mem[word_idx];
    // Any bit above the array's byte range makes the access illegal; there is
    // no index wrap-around.
    assign addr_bad = (addr_q[1:0] != 2'b00) ||
                      ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign capture  = (state == S_IDLE) && MEM_Request;
    // The single array access happens on the edge that leaves WAIT.
    assign access   = (state == S_WAIT) && (wait_count == 4'd0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (MEM_Request) next_state = S_WAIT;
            S_WAIT:  if (wait_count == 4'd0) next_state = S_DONE;
            S_DONE:  if (!MEM_Request) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            wait_count    <= 4'd0;
            MEM_Out       <= 32'd0;
            MFC           <= 1'b0;
            Busy          <= 1'b0;
            Address_Error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MEM_Request) begin
                        wait_count <= WAIT_LOAD;
                        Busy       <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wait_count != 4'd0) begin
                        wait_count <= wait_count - 4'd1;
                    end else begin
                        MFC           <= 1'b1;
                        Address_Error <= addr_bad;
                        // Writes leave MEM_Out holding the last read result.
                        if (read_q) begin
                            MEM_Out <= addr_bad ? 32'd0 : rd_word;
                        end
                    end
                end
                S_DONE: begin
                    if (!MEM_Request) begin
                        MFC           <= 1'b0;
                        Address_Error <= 1'b0;
                        Busy          <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Request capture (no reset needed: only consumed after a capture)
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (capture) begin
            addr_q <= MEM_Address;
            data_q <= MEM_In;
            read_q <= MEM_Read_H_Write_L;
        end
    end

    // ------------------------------------------------------------------
    // Array write port. Contents survive reset; a reset during WAIT returns
    // the FSM to IDLE asynchronously so the pending write never fires.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (access && !read_q && !addr_bad) begin
            mem[word_idx] <= data_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_responder
//  Description : Self-checking bench for data_memory_responder. Two instances
//                (WAIT_STATES=2 and WAIT_STATES=0) share clock, reset and
//                address/data/direction buses but have separate requests.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_memory_responder;

    logic        Clock;
    logic        Reset_L;
    logic        req_a, req_b;
    logic        rw_s;
    logic [31:0] addr_s, din_s;
    logic [31:0] out_a, out_b;
    logic        mfc_a, mfc_b, busy_a, busy_b, err_a, err_b;

    data_memory_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2), .INIT_FILE("")) dut_a (
        .Clock(Clock), .Reset_L(Reset_L), .MEM_Request(req_a),
        .MEM_Read_H_Write_L(rw_s), .MEM_Address(addr_s), .MEM_In(din_s),
        .MEM_Out(out_a), .MFC(mfc_a), .Busy(busy_a), .Address_Error(err_a)
    );

    data_memory_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0), .INIT_FILE("")) dut_b (
        .Clock(Clock), .Reset_L(Reset_L), .MEM_Request(req_b),
        .MEM_Read_H_Write_L(rw_s), .MEM_Address(addr_s), .MEM_In(din_s),
        .MEM_Out(out_b), .MFC(mfc_b), .Busy(busy_b), .Address_Error(err_b)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_mis = 0;

    // ---------------- reference model (per instance) ----------------
    logic [31:0] mm       [2][256];
    bit          known    [2][256];
    logic [31:0] last_out [2];
    bit          last_known[2];

    function automatic bit addr_is_error(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'h400);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            last_out[s]   = 32'd0;
            last_known[s] = 1'b1;
        end
    endtask

    task automatic model_apply(input int sel, input logic rw, input logic [31:0] a,
                               input logic [31:0] d, output logic [31:0] eo,
                               output bit eo_valid, output bit ee);
        int idx;
        ee  = addr_is_error(a);
        idx = int'(a / 4) % 256;
        if (rw) begin
            if (ee) begin
                last_out[sel] = 32'd0; last_known[sel] = 1'b1;
            end else begin
                last_out[sel] = mm[sel][idx]; last_known[sel] = known[sel][idx];
            end
        end else if (!ee) begin
            mm[sel][idx] = d; known[sel][idx] = 1'b1;
        end
        eo = last_out[sel]; eo_valid = last_known[sel];
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic mfc_of(input int sel);  return sel == 0 ? mfc_a  : mfc_b;  endfunction
    function automatic logic busy_of(input int sel); return sel == 0 ? busy_a : busy_b; endfunction
    function automatic logic err_of(input int sel);  return sel == 0 ? err_a  : err_b;  endfunction
    function automatic logic [31:0] out_of(input int sel); return sel == 0 ? out_a : out_b; endfunction

    // One full 4-phase handshake. Inputs are driven 1 ns after a rising edge
    // and outputs sampled 1 ns after the following edges.
    task automatic do_access(input int sel, input logic rw, input logic [31:0] a,
                             input logic [31:0] d, input int hold, input bit scramble,
                             output logic [31:0] got_out, output logic got_err);
        int lat;
        int bad_hold;
        @(posedge Clock); #1;
        rw_s = rw; addr_s = a; din_s = d;
        if (sel == 0) req_a = 1'b1; else req_b = 1'b1;
        @(posedge Clock); #1;                       // capture edge k
        check("busy_after_capture", {31'd0, busy_of(sel)}, 32'd1);
        if (scramble) begin
            addr_s = $urandom; din_s = $urandom; rw_s = ~rw;
        end
        lat = 0;
        while (mfc_of(sel) !== 1'b1 && lat < 40) begin
            @(posedge Clock); #1;
            lat++;
        end
        check("mfc_latency", lat, (sel == 0) ? 32'd3 : 32'd1);
        got_out = out_of(sel);
        got_err = err_of(sel);
        bad_hold = 0;
        for (int h = 0; h < hold; h++) begin
            if (scramble) begin addr_s = $urandom; din_s = $urandom; end
            @(posedge Clock); #1;
            if (mfc_of(sel) !== 1'b1 || busy_of(sel) !== 1'b1 ||
                out_of(sel) !== got_out || err_of(sel) !== got_err) bad_hold++;
        end
        if (hold > 0) check("hold_stable", bad_hold, 32'd0);
        req_a = 1'b0; req_b = 1'b0;
        @(posedge Clock); #1;
        check("mfc_after_drop",  {31'd0, mfc_of(sel)},  32'd0);
        check("busy_after_drop", {31'd0, busy_of(sel)}, 32'd0);
        check("err_after_drop",  {31'd0, err_of(sel)},  32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_out;
        logic        exp_err;
        bit          chk_out;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] o, eo;
        logic        e;
        bit          eov, ee;
        int          sel, cls, hold;
        logic [31:0] a, d;
        logic        rw;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++) begin mm[s][i] = 32'd0; known[s][i] = 1'b0; end

        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 32'h0000_0014, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 32'h0000_03FC, 32'h0,         32'hA5A5_A5A5, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_03FD, 32'h0,         32'h0000_0000, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 32'h8000_0010, 32'h5555_5555, 32'h0000_0000, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, 1'b1};

        Reset_L = 1'b0; req_a = 1'b0; req_b = 1'b0;
        rw_s = 1'b1; addr_s = 32'd0; din_s = 32'd0;
        model_reset();
        repeat (3) @(posedge Clock);
        #1;
        check("rst_mfc_a",  {31'd0, mfc_a},  32'd0);
        check("rst_busy_a", {31'd0, busy_a}, 32'd0);
        check("rst_err_a",  {31'd0, err_a},  32'd0);
        check("rst_out_a",  out_a,           32'd0);
        check("rst_mfc_b",  {31'd0, mfc_b},  32'd0);
        check("rst_busy_b", {31'd0, busy_b}, 32'd0);
        check("rst_out_b",  out_b,           32'd0);
        @(negedge Clock) Reset_L = 1'b1;

        // Table of directed accesses on the 2-wait-state instance.
        for (int v = 0; v < 11; v++) begin
            do_access(0, vecs[v].rw, vecs[v].addr, vecs[v].data, 0, 1'b0, o, e);
            model_apply(0, vecs[v].rw, vecs[v].addr, vecs[v].data, eo, eov, ee);
            check($sformatf("vec%0d_err", v), {31'd0, e}, {31'd0, vecs[v].exp_err});
            if (vecs[v].chk_out) check($sformatf("vec%0d_out", v), o, vecs[v].exp_out);
        end

        // Held request plus bus changes during WAIT/DONE: captured values win.
        do_access(0, 1'b0, 32'h44, 32'h5555_6666, 0, 1'b0, o, e);
        model_apply(0, 1'b0, 32'h44, 32'h5555_6666, eo, eov, ee);
        do_access(0, 1'b0, 32'h40, 32'h1111_2222, 10, 1'b1, o, e);
        model_apply(0, 1'b0, 32'h40, 32'h1111_2222, eo, eov, ee);
        do_access(0, 1'b1, 32'h40, 32'h0, 10, 1'b1, o, e);
        model_apply(0, 1'b1, 32'h40, 32'h0, eo, eov, ee);
        check("hold_read_40", o, 32'h1111_2222);
        do_access(0, 1'b1, 32'h44, 32'h0, 0, 1'b0, o, e);
        model_apply(0, 1'b1, 32'h44, 32'h0, eo, eov, ee);
        check("hold_read_44", o, 32'h5555_6666);

        // Zero-wait-state instance: MFC one edge after capture.
        do_access(1, 1'b0, 32'h30, 32'h0F0F_0F0F, 0, 1'b0, o, e);
        model_apply(1, 1'b0, 32'h30, 32'h0F0F_0F0F, eo, eov, ee);
        do_access(1, 1'b1, 32'h30, 32'h0, 2, 1'b1, o, e);
        model_apply(1, 1'b1, 32'h30, 32'h0, eo, eov, ee);
        check("ws0_read_30", o, 32'h0F0F_0F0F);
        check("ws0_err_30",  {31'd0, e}, 32'd0);

        // Asynchronous reset in the middle of a write's wait period.
        do_access(0, 1'b0, 32'h20, 32'h0BAD_BEEF, 0, 1'b0, o, e);
        model_apply(0, 1'b0, 32'h20, 32'h0BAD_BEEF, eo, eov, ee);
        do_access(0, 1'b1, 32'h20, 32'h0, 0, 1'b0, o, e);
        model_apply(0, 1'b1, 32'h20, 32'h0, eo, eov, ee);
        check("pre_reset_read", o, 32'h0BAD_BEEF);
        @(posedge Clock); #1;
        rw_s = 1'b0; addr_s = 32'h20; din_s = 32'hCAFE_F00D; req_a = 1'b1;
        @(posedge Clock); #1;                       // capture
        @(posedge Clock); #1;                       // still waiting
        #2 Reset_L = 1'b0;
        #1;
        check("async_rst_mfc",  {31'd0, mfc_a},  32'd0);
        check("async_rst_busy", {31'd0, busy_a}, 32'd0);
        check("async_rst_out",  out_a,           32'd0);
        req_a = 1'b0;
        model_reset();
        repeat (2) @(posedge Clock);
        @(negedge Clock) Reset_L = 1'b1;
        do_access(0, 1'b1, 32'h20, 32'h0, 0, 1'b0, o, e);
        model_apply(0, 1'b1, 32'h20, 32'h0, eo, eov, ee);
        check("post_reset_read", o, 32'h0BAD_BEEF);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 1);
            cls = $urandom_range(0, 9);
            rw  = 1'(($urandom_range(0, 1)));
            d   = $urandom;
            if (cls == 0) begin
                a = 32'($urandom_range(0, 1023));
                if (a[1:0] == 2'b00) a = a | 32'd1;
            end else if (cls == 1) begin
                a = $urandom | 32'h0000_0400;
            end else if (cls < 6) begin
                a = 32'($urandom_range(0, 7)) * 4;
            end else begin
                a = 32'h3E0 + 32'($urandom_range(0, 7)) * 4;
            end
            hold = $urandom_range(0, 3);
            do_access(sel, rw, a, d, hold, 1'($urandom_range(0, 1)), o, e);
            model_apply(sel, rw, a, d, eo, eov, ee);
            check($sformatf("rnd%0d_err", n), {31'd0, e}, {31'd0, ee});
            if (eov) check($sformatf("rnd%0d_out", n), o, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
